// File: rtl/bcd_seg_scan.sv
// -----------------------------------------------------------------------------
// bcd_seg_scan
//   Drives a 3-digit multiplexed 7-segment display from the three BCD digits
//   of the binary-to-BCD converter. The digits are snapshotted once per frame,
//   so a value changing mid-frame never shows up as a torn reading. Each digit
//   slot opens with BLANK_CYC cycles of all-selects-off to suppress ghosting.
//
// Parameters
//   SCAN_DIV   clock cycles per digit slot (4 .. 2^20)
//   BLANK_CYC  leading cycles of each slot with every select inactive (< SCAN_DIV)
//   ACT_LOW    1: seg/sel active-low, 0: active-high
//
// Ports
//   clk         system clock
//   rst         synchronous reset, active-high
//   en          scan enable; 0 freezes cnt/slot/snapshot and blanks the display
//   dig0..dig2  BCD ones / tens / hundreds digits
//   seg         segments, [7]=dp (always off), [6:0]=g..a
//   sel         one-hot digit select, [0]=ones, [2]=hundreds
//   frame_tick  one-cycle pulse in the output cycle of slot 0, cnt 0
//
// Build option
//   SEG_LZB_EN  when defined, leading zeros are blanked: hundreds when its
//               snapshot digit is 0, tens when hundreds and tens are both 0.
//               Ones is never blanked; codes A-F never count as zero.
//
// Slot states
//   SLOT_ONES  | driving the ones digit     (sel[0])
//   SLOT_TENS  | driving the tens digit     (sel[1])
//   SLOT_HUNDS | driving the hundreds digit (sel[2]); wrap reloads snapshot
// -----------------------------------------------------------------------------
module bcd_seg_scan #(
    parameter int SCAN_DIV  = 50000,
    parameter int BLANK_CYC = 4,
    parameter int ACT_LOW   = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [3:0] dig0,
    input  logic [3:0] dig1,
    input  logic [3:0] dig2,
    output logic [7:0] seg,
    output logic [2:0] sel,
    output logic       frame_tick
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYC);
    // XOR-ing an active-high pattern with the "off" pattern yields the
    // pin-level value for either polarity.
    localparam logic [7:0] SEG_OFF = (ACT_LOW != 0) ? 8'hFF : 8'h00;
    localparam logic [2:0] SEL_OFF = (ACT_LOW != 0) ? 3'b111 : 3'b000;

    typedef enum logic [1:0] {
        SLOT_ONES  = 2'd0,
        SLOT_TENS  = 2'd1,
        SLOT_HUNDS = 2'd2
    } slot_t;

    slot_t         slot;
    logic [CW-1:0] cnt;
    logic [3:0]    snap0, snap1, snap2;
    logic          load_pending;

    logic [3:0]    eff0, eff1, eff2;
    logic [3:0]    cur_digit;
    logic [2:0]    sel_hot;
    logic          slot_blank;
    logic [7:0]    seg_hot;

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    return 7'h3F;
            4'd1:    return 7'h06;
            4'd2:    return 7'h5B;
            4'd3:    return 7'h4F;
            4'd4:    return 7'h66;
            4'd5:    return 7'h6D;
            4'd6:    return 7'h7D;
            4'd7:    return 7'h07;
            4'd8:    return 7'h7F;
            4'd9:    return 7'h6F;
            default: return 7'h40;  // invalid BCD shows a dash
        endcase
    endfunction

    // On the very first enabled cycle the snapshot is being loaded this
    // same cycle, so display from the incoming digits rather than stale zeros.
    always_comb begin
        eff0       = load_pending ? dig0 : snap0;
        eff1       = load_pending ? dig1 : snap1;
        eff2       = load_pending ? dig2 : snap2;
        cur_digit  = eff0;
        sel_hot    = 3'b001;
        slot_blank = 1'b0;
        case (slot)
            SLOT_TENS: begin
                cur_digit = eff1;
                sel_hot   = 3'b010;
`ifdef SEG_LZB_EN
                slot_blank = (eff2 == 4'd0) && (eff1 == 4'd0);
`endif
            end
            SLOT_HUNDS: begin
                cur_digit = eff2;
                sel_hot   = 3'b100;
`ifdef SEG_LZB_EN
                slot_blank = (eff2 == 4'd0);
`endif
            end
            default: begin
                cur_digit = eff0;
                sel_hot   = 3'b001;
            end
        endcase
        seg_hot = {1'b0, seg_decode(cur_digit)};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt          <= '0;
            slot         <= SLOT_ONES;
            snap0        <= 4'd0;
            snap1        <= 4'd0;
            snap2        <= 4'd0;
            load_pending <= 1'b1;
            seg          <= SEG_OFF;
            sel          <= SEL_OFF;
            frame_tick   <= 1'b0;
        end else if (en) begin
            frame_tick <= (slot == SLOT_ONES) && (cnt == '0);
            if ((cnt >= CNT_BLANK) && !slot_blank) begin
                sel <= sel_hot ^ SEL_OFF;
                seg <= seg_hot ^ SEG_OFF;
            end else begin
                sel <= SEL_OFF;
                seg <= SEG_OFF;
            end

            if (load_pending) begin
                snap0        <= dig0;
                snap1        <= dig1;
                snap2        <= dig2;
                load_pending <= 1'b0;
            end

            if (cnt == CNT_LAST) begin
                cnt <= '0;
                case (slot)
                    SLOT_ONES: slot <= SLOT_TENS;
                    SLOT_TENS: slot <= SLOT_HUNDS;
                    default: begin
                        slot  <= SLOT_ONES;
                        snap0 <= dig0;
                        snap1 <= dig1;
                        snap2 <= dig2;
                    end
                endcase
            end else begin
                cnt <= cnt + 1'b1;
            end
        end else begin
            sel        <= SEL_OFF;
            seg        <= SEG_OFF;
            frame_tick <= 1'b0;
        end
    end

endmodule

// File: tb/tb_bcd_seg_scan.sv
// -----------------------------------------------------------------------------
// tb_bcd_seg_scan
//   Directed bench for bcd_seg_scan with SCAN_DIV=8, BLANK_CYC=2, ACT_LOW=1.
//   Expected segment codes are the active-low values of the BCD table.
//   Build with SEG_LZB_EN defined to exercise leading-zero blanking.
// -----------------------------------------------------------------------------
module tb_bcd_seg_scan;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b0;
    logic [3:0] dig0 = 4'd0, dig1 = 4'd0, dig2 = 4'd0;
    logic [7:0] seg;
    logic [2:0] sel;
    logic       frame_tick;

    int vecs = 0;
    int errs = 0;

    bcd_seg_scan #(.SCAN_DIV(8), .BLANK_CYC(2), .ACT_LOW(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .dig0       (dig0),
        .dig1       (dig1),
        .dig2       (dig2),
        .seg        (seg),
        .sel        (sel),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        chk("rst_sel", 32'(sel), 32'h7);
        chk("rst_seg", 32'(seg), 32'hFF);
        chk("rst_tick", 32'(frame_tick), 32'h0);
        rst = 1'b0;
    endtask

    // Checks output cycles first..last of one slot; index i is the slot's cnt.
    task automatic run_slot(input string tag, input logic [2:0] sel_exp,
                            input logic [7:0] seg_exp, input logic tick_first,
                            input int first, input int last);
        for (int i = first; i <= last; i++) begin
            step();
            if (i < 2) begin
                chk({tag, "_blank_sel"}, 32'(sel), 32'h7);
                chk({tag, "_blank_seg"}, 32'(seg), 32'hFF);
            end else begin
                chk({tag, "_sel"}, 32'(sel), 32'(sel_exp));
                chk({tag, "_seg"}, 32'(seg), 32'(seg_exp));
            end
            chk({tag, "_tick"}, 32'(frame_tick), 32'((tick_first && i == 0) ? 1 : 0));
        end
    endtask

    initial begin
        // 1: basic scan of 2/5/5, frame period 24
        en = 1'b0;
        do_reset();
        dig2 = 4'd2; dig1 = 4'd5; dig0 = 4'd5;
        en = 1'b1;
        run_slot("t1_ones", 3'b110, 8'h92, 1'b1, 0, 7);
        run_slot("t1_tens", 3'b101, 8'h92, 1'b0, 0, 7);
        run_slot("t1_hund", 3'b011, 8'hA4, 1'b0, 0, 7);
        run_slot("t1_ones2", 3'b110, 8'h92, 1'b1, 0, 7);

        // 2: leading zeros 0/0/7 (reset taken with en still high)
        dig2 = 4'd0; dig1 = 4'd0; dig0 = 4'd7;
        do_reset();
        run_slot("t2_ones", 3'b110, 8'hF8, 1'b1, 0, 7);
`ifdef SEG_LZB_EN
        run_slot("t2_tens", 3'b111, 8'hFF, 1'b0, 0, 7);
        run_slot("t2_hund", 3'b111, 8'hFF, 1'b0, 0, 7);
`else
        run_slot("t2_tens", 3'b101, 8'hC0, 1'b0, 0, 7);
        run_slot("t2_hund", 3'b011, 8'hC0, 1'b0, 0, 7);
`endif

        // 3: inputs change mid-slot 1; take effect only next frame
        dig2 = 4'd1; dig1 = 4'd2; dig0 = 4'd3;
        do_reset();
        run_slot("t3_ones", 3'b110, 8'hB0, 1'b1, 0, 7);
        run_slot("t3_tens_a", 3'b101, 8'hA4, 1'b0, 0, 3);
        dig2 = 4'd4; dig1 = 4'd5; dig0 = 4'd6;
        run_slot("t3_tens_b", 3'b101, 8'hA4, 1'b0, 4, 7);
        run_slot("t3_hund", 3'b011, 8'hF9, 1'b0, 0, 7);
        run_slot("t3_ones_n", 3'b110, 8'h82, 1'b1, 0, 7);

        // 4: en dropped in slot 1 at cnt=5, then resumed
        run_slot("t4_tens_a", 3'b101, 8'h92, 1'b0, 0, 4);
        en = 1'b0;
        step();
        chk("t4_hold_sel", 32'(sel), 32'h7);
        chk("t4_hold_seg", 32'(seg), 32'hFF);
        chk("t4_hold_tick", 32'(frame_tick), 32'h0);
        chk("t4_hold_cnt", 32'(dut.cnt), 32'd5);
        step();
        chk("t4_hold_cnt2", 32'(dut.cnt), 32'd5);
        chk("t4_hold_slot", 32'(dut.slot), 32'd1);
        en = 1'b1;
        run_slot("t4_tens_b", 3'b101, 8'h92, 1'b0, 5, 7);
        run_slot("t4_hund", 3'b011, 8'h99, 1'b0, 0, 7);

        // 5: rst mid-slot 2, new inputs captured on first enabled cycle
        run_slot("t5_ones", 3'b110, 8'h82, 1'b1, 0, 7);
        run_slot("t5_tens", 3'b101, 8'h92, 1'b0, 0, 7);
        run_slot("t5_hund_a", 3'b011, 8'h99, 1'b0, 0, 3);
        dig2 = 4'd9; dig1 = 4'd8; dig0 = 4'd7;
        do_reset();
        chk("t5_cnt", 32'(dut.cnt), 32'd0);
        chk("t5_slot", 32'(dut.slot), 32'd0);
        chk("t5_pending", 32'(dut.load_pending), 32'd1);
        run_slot("t5_ones_n", 3'b110, 8'hF8, 1'b1, 0, 7);
        run_slot("t5_tens_n", 3'b101, 8'h80, 1'b0, 0, 7);
        run_slot("t5_hund_n", 3'b011, 8'h90, 1'b0, 0, 7);

        // 6: invalid codes show a dash and are never blanked as zero
        dig2 = 4'hA; dig1 = 4'd0; dig0 = 4'hC;
        do_reset();
        run_slot("t6_ones", 3'b110, 8'hBF, 1'b1, 0, 7);
        run_slot("t6_tens", 3'b101, 8'hC0, 1'b0, 0, 7);
        run_slot("t6_hund", 3'b011, 8'hBF, 1'b0, 0, 7);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/bcd_seg_scan.md
Name: bcd_seg_scan

Overview:
- Downstream consumer of the pipelined binary-to-BCD converter.
- Takes its three BCD digits (ones, tens, hundreds) and drives a 3-digit multiplexed 7-segment display.
- Snapshots the digits once per frame, time-multiplexes the digit selects, and decodes BCD to segments.
- Applies anti-ghosting blank time at every digit switch.

Parameters:
- SCAN_DIV, 50000: clock cycles per digit slot; legal range 4..2^20.
- BLANK_CYC, 4: cycles at the start of each slot with all selects inactive; must be < SCAN_DIV.
- ACT_LOW, 1: 1 means seg and sel outputs are active-low; 0 means active-high.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- en  in  1  scan enable
- dig0  in  4  BCD ones digit (from the converter's dec_out0)
- dig1  in  4  BCD tens digit
- dig2  in  4  BCD hundreds digit
- seg  out  8  [7]=dp, [6:0]=g..a
- sel  out  3  one-hot digit select; [0]=ones, [2]=hundreds
- frame_tick  out  1  one-cycle pulse at each frame start

Behaviour:
- Reset is synchronous, active-high; clk is the only clock.
- Reset state: cnt=0, slot=0, snapshot=0, load_pending=1. Outputs are registered: seg all-off, sel all-inactive, frame_tick=0. "Off/inactive" means all-ones when ACT_LOW=1, all-zeros when ACT_LOW=0.
- Slot counter cnt counts 0..SCAN_DIV-1 while en=1.
- When cnt==SCAN_DIV-1: next cycle cnt=0 and slot advances 0->1->2->0.
- Snapshot:
  - On the slot 2->0 wrap, dig0..2 are captured into snapshot.
  - On the first en=1 cycle after reset (load_pending=1), dig0..2 are also captured and load_pending clears.
  - Input changes at any other time have no visible effect.
- frame_tick pulses 1 in the output cycle corresponding to slot 0, cnt 0. Period is 3*SCAN_DIV cycles.
- Output timing: outputs are registered and lag internal state by one cycle.
- Select: sel[slot] is active only when cnt >= BLANK_CYC; otherwise all selects are inactive.
- Segment decode (active-high g..a): 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - Codes A-F decode to a dash, 40.
  - dp is always off.
  - ACT_LOW=1 inverts all 8 bits.
- seg carries the decode of the current slot's snapshot digit whenever sel is active; otherwise seg is off.
- en=0: cnt, slot and snapshot hold. The next cycle, sel is inactive, seg is off and frame_tick=0. When en returns to 1, scanning resumes from the held cnt/slot.
- rst asserted mid-frame: the next cycle equals the reset state. No partial-frame residue.
- Simultaneous rst and en: rst wins.

Optional Feature:
- Macro: SEG_LZB_EN (leading-zero blanking).
- Defined:
  - Hundreds slot is blanked when snapshot dig2==0.
  - Tens slot is blanked when dig2==0 and dig1==0.
  - Ones slot is never blanked.
  - A blanked slot keeps its timing, but sel stays inactive and seg stays off for the whole slot.
  - Invalid codes (A-F) are never treated as zero.
- Undefined: all three digits are always shown, including leading zeros.

Test Plan (SCAN_DIV=8, BLANK_CYC=2, ACT_LOW=1):
1. Reset, then en=1 with dig2/1/0=2/5/5:
   - Slot 0: sel=3'b110 with seg=8'h92 (5).
   - Slot 1: sel=3'b101 with seg=8'h92 (5).
   - Slot 2: sel=3'b011 with seg=8'hA4 (2).
   - In each slot, sel is active for 6 cycles after 2 blank cycles.
   - frame_tick period is 24 cycles.
2. SEG_LZB_EN defined, inputs 0/0/7:
   - Ones slot shows seg=8'hF8.
   - Tens and hundreds slots keep sel=3'b111 and seg=8'hFF throughout.
   - Repeat undefined: seg=8'hC0 (0) on the tens and hundreds slots.
3. Inputs change from 1/2/3 to 4/5/6 mid-slot 1:
   - Remaining slots of the frame still show 1/2/3.
   - The next frame shows 4/5/6.
4. en dropped during slot 1 at cnt=5:
   - Next cycle sel=3'b111, seg=8'hFF, cnt held.
   - After en is restored, slot 1 resumes from cnt=5 and the slot lasts 3 more cycles.
5. rst pulsed mid-slot 2:
   - Next cycle all outputs are inactive, cnt=0, slot=0.
   - New inputs are captured on the first enabled cycle.
6. dig0=4'hC: the ones slot shows seg=8'hBF (dash); with SEG_LZB_EN, dig2=4'hA is not blanked.
